conv_mac: RTL and testbench



---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_mac_sat.sv | 34 +++
 rtl/conv_mac.sv | 171 +++++++++++++++++
 tb/tb_conv_mac.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution filter chain: coefficient type,
// accumulator sizing, default coefficient set and window edge strategies.
package conv_pkg;

    localparam int COEFF_W_DEFAULT = 8;

    typedef logic signed [COEFF_W_DEFAULT-1:0] coeff_t;

    // Edge-extension strategies understood by the window stage.
    localparam string EXTEND_ZERO      = "ZERO";
    localparam string EXTEND_REPLICATE = "REPLICATE";
    localparam string EXTEND_MIRROR    = "MIRROR";

    // Width that holds the sum of kernel_size signed products without overflow.
    function automatic int acc_width(input int pixel_w, input int coeff_w, input int kernel_size);
        return pixel_w + coeff_w + 1 + $clog2(kernel_size);
    endfunction

    // Identity kernel: centre tap scaled by 2^shift, so the output shift restores it.
    function automatic int default_coeff(input int idx, input int kernel_size, input int shift);
        return (idx == kernel_size / 2) ? (1 << shift) : 0;
    endfunction

endpackage

// File: rtl/conv_mac_sat.sv
// Round-half-up, arithmetic right shift and clamp of a signed accumulator
// down to an unsigned pixel. Purely combinational.
module conv_mac_sat #(
    parameter int ACC_W   = 21,
    parameter int SHIFT_N = 4,
    parameter int PIXEL_W = 8
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic        [PIXEL_W-1:0] pix
);

    // Half an output LSB; one extra bit keeps the addition from wrapping.
    localparam logic signed [ACC_W:0] RND =
        (SHIFT_N > 0) ? ((ACC_W+1)'(1) << ((SHIFT_N > 0) ? (SHIFT_N - 1) : 0)) : '0;

    function automatic logic [PIXEL_W-1:0] round_sat(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W:0] t;
        t = $signed({s[ACC_W-1], s}) + RND;
        t = t >>> SHIFT_N;
        if (t[ACC_W]) begin
            return '0;
        end else if (|t[ACC_W-1:PIXEL_W]) begin
            return '1;
        end else begin
            return t[PIXEL_W-1:0];
        end
    endfunction

    // Map the accumulated sum onto the pixel range.
    always_comb begin
        pix = round_sat(sum);
    end

endmodule

// File: rtl/conv_mac.sv
// Multiply-accumulate stage of the streaming convolution: per-tap signed
// coefficients with frame-synchronous bank switching, 3-stage elastic
// pipeline (MUL, SUM, OUT) with full backpressure.
module conv_mac
    import conv_pkg::*;
#(
    parameter int PIXEL_W           = 8,
    parameter int KERNEL_DIAMETER_N = 5,
    parameter int COEFF_W           = 8,
    parameter int SHIFT_N           = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        s_tvalid_i,
    input  logic [KERNEL_DIAMETER_N*2*PIXEL_W-1:0]      s_tdata_i,
    input  logic                                        s_tuser_i,
    input  logic                                        s_tlast_i,
    output logic                                        s_tready_o,
    output logic                                        m_tvalid_o,
    output logic [PIXEL_W-1:0]                          m_tdata_o,
    output logic                                        m_tuser_o,
    output logic                                        m_tlast_o,
    input  logic                                        m_tready_i,
    input  logic                                        cfg_we_i,
    input  logic [$clog2(KERNEL_DIAMETER_N*2)-1:0]      cfg_addr_i,
    input  logic signed [COEFF_W-1:0]                   cfg_data_i
);

    localparam int KERNEL_SIZE_N = KERNEL_DIAMETER_N * 2;
    localparam int ACC_W         = acc_width(PIXEL_W, COEFF_W, KERNEL_SIZE_N);
    localparam int PROD_W        = PIXEL_W + COEFF_W + 1;

    logic adv1, adv2, adv3;
    logic accept, commit, addr_ok;
    logic vld_p1, vld_p2, vld_p3;
    logic user_p1, last_p1, user_p2, last_p2;

    logic signed [COEFF_W-1:0] shadow     [KERNEL_SIZE_N];
    logic signed [COEFF_W-1:0] shadow_nxt [KERNEL_SIZE_N];
    logic signed [COEFF_W-1:0] active     [KERNEL_SIZE_N];
    logic signed [COEFF_W-1:0] coef_sel   [KERNEL_SIZE_N];

    logic signed [PROD_W-1:0] mul_c   [KERNEL_SIZE_N];
    logic signed [PROD_W-1:0] prod_p1 [KERNEL_SIZE_N];
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  sum_p2;
    logic [PIXEL_W-1:0]       sat_pix;

    // A stage advances when it is empty or its content leaves this cycle.
    assign adv3       = m_tready_i | ~vld_p3;
    assign adv2       = adv3 | ~vld_p2;
    assign adv1       = adv2 | ~vld_p1;
    assign s_tready_o = adv1;
    assign m_tvalid_o = vld_p3;

    assign accept  = s_tvalid_i & adv1;
    assign commit  = accept & s_tuser_i;
    assign addr_ok = int'(cfg_addr_i) < KERNEL_SIZE_N;

    // Shadow bank as it will be after this edge, including a same-cycle write.
    always_comb begin
        for (int i = 0; i < KERNEL_SIZE_N; i++) begin
            shadow_nxt[i] = shadow[i];
        end
        if (cfg_we_i && addr_ok) begin
            shadow_nxt[cfg_addr_i] = cfg_data_i;
        end
    end

    // Coefficient banks: shadow follows writes, active switches only on a frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KERNEL_SIZE_N; i++) begin
                shadow[i] <= COEFF_W'(default_coeff(i, KERNEL_SIZE_N, SHIFT_N));
                active[i] <= COEFF_W'(default_coeff(i, KERNEL_SIZE_N, SHIFT_N));
            end
        end else begin
            shadow <= shadow_nxt;
            if (commit) begin
                active <= shadow_nxt;
            end
        end
    end

    // ---- Stage 1: MUL ----

    // The frame-start beat itself already uses the bank it commits.
    always_comb begin
        for (int i = 0; i < KERNEL_SIZE_N; i++) begin
            coef_sel[i] = commit ? shadow_nxt[i] : active[i];
            mul_c[i]    = $signed({{(COEFF_W+1){1'b0}}, s_tdata_i[i*PIXEL_W +: PIXEL_W]})
                        * $signed({{(PIXEL_W+1){coef_sel[i][COEFF_W-1]}}, coef_sel[i]});
        end
    end

    // Per-tap product register.
    always_ff @(posedge clk) begin
        if (adv1 && s_tvalid_i) begin
            prod_p1 <= mul_c;
        end
    end

    // Valid bits and frame markers travel alongside the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            user_p1 <= 1'b0;
            last_p1 <= 1'b0;
            user_p2 <= 1'b0;
            last_p2 <= 1'b0;
        end else begin
            if (adv1) begin
                vld_p1  <= s_tvalid_i;
                user_p1 <= s_tuser_i;
                last_p1 <= s_tlast_i;
            end
            if (adv2) begin
                vld_p2  <= vld_p1;
                user_p2 <= user_p1;
                last_p2 <= last_p1;
            end
            if (adv3) begin
                vld_p3 <= vld_p2;
            end
        end
    end

    // ---- Stage 2: SUM ----

    // Sign-extended sum of all products; ACC_W is wide enough to never wrap.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < KERNEL_SIZE_N; i++) begin
            sum_c = sum_c + $signed({{(ACC_W-PROD_W){prod_p1[i][PROD_W-1]}}, prod_p1[i]});
        end
    end

    // Accumulated sum register.
    always_ff @(posedge clk) begin
        if (adv2 && vld_p1) begin
            sum_p2 <= sum_c;
        end
    end

    // ---- Stage 3: OUT ----

    conv_mac_sat #(
        .ACC_W   (ACC_W),
        .SHIFT_N (SHIFT_N),
        .PIXEL_W (PIXEL_W)
    ) u_sat (
        .sum (sum_p2),
        .pix (sat_pix)
    );

    // Output register; holds while a valid pixel waits for m_tready_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tdata_o <= '0;
            m_tuser_o <= 1'b0;
            m_tlast_o <= 1'b0;
        end else if (adv3 && vld_p2) begin
            m_tdata_o <= sat_pix;
            m_tuser_o <= user_p2;
            m_tlast_o <= last_p2;
        end
    end

endmodule

// File: tb/tb_conv_mac.sv
// Directed and randomised checks of conv_mac: reset state, latency,
// identity kernel, saturation/rounding, commit boundary, backpressure, reset.
module tb_conv_mac;

    localparam int PW = 8;
    localparam int KD = 5;
    localparam int CW = 8;
    localparam int SH = 4;
    localparam int KS = KD * 2;
    localparam int AW = $clog2(KS);

    logic              clk = 1'b0;
    logic              rst;
    logic              s_tvalid, s_tuser, s_tlast, s_tready;
    logic [KS*PW-1:0]  s_tdata;
    logic              m_tvalid, m_tuser, m_tlast, m_tready;
    logic [PW-1:0]     m_tdata;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [CW-1:0]     cfg_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic last_acc = 1'b0;

    int sh_m [KS];
    int act_m [KS];
    logic [9:0] got_q [$];
    logic [9:0] exp_q [$];

    typedef struct {
        logic [KS*PW-1:0] taps;
        logic             user;
        logic             last;
        logic [PW-1:0]    exp;
    } vec_t;
    vec_t tbl [6];

    conv_mac #(
        .PIXEL_W(PW), .KERNEL_DIAMETER_N(KD), .COEFF_W(CW), .SHIFT_N(SH)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tvalid_i(s_tvalid), .s_tdata_i(s_tdata), .s_tuser_i(s_tuser),
        .s_tlast_i(s_tlast), .s_tready_o(s_tready),
        .m_tvalid_o(m_tvalid), .m_tdata_o(m_tdata), .m_tuser_o(m_tuser),
        .m_tlast_o(m_tlast), .m_tready_i(m_tready),
        .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data)
    );

    always #5 clk = ~clk;

    // Output handshakes are recorded mid-cycle, before the edge that completes them.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) got_q.push_back({m_tuser, m_tlast, m_tdata});
    end

    function automatic int dflt(input int i);
        return (i == KS / 2) ? (1 << SH) : 0;
    endfunction

    function automatic logic [PW-1:0] model(input logic [KS*PW-1:0] t, input int c [KS]);
        longint s;
        s = 0;
        for (int i = 0; i < KS; i++) s += longint'(t[i*PW +: PW]) * longint'(c[i]);
        if (SH > 0) s += longint'(1) << (SH - 1);
        s = s >>> SH;
        if (s < 0) return '0;
        if (s > (1 << PW) - 1) return '1;
        return s[PW-1:0];
    endfunction

    function automatic logic [KS*PW-1:0] mk2(input logic [7:0] fill, input int a,
                                             input logic [7:0] va, input int b, input logic [7:0] vb);
        logic [KS*PW-1:0] v;
        for (int i = 0; i < KS; i++) v[i*PW +: PW] = fill;
        v[a*PW +: PW] = va;
        v[b*PW +: PW] = vb;
        return v;
    endfunction

    function automatic logic [KS*PW-1:0] mk(input logic [7:0] fill, input int a, input logic [7:0] va);
        return mk2(fill, a, va, a, va);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock edge with the currently driven inputs; updates the reference model.
    task automatic do_edge();
        #1;
        last_acc = s_tvalid && s_tready && !rst;
        if (rst) begin
            for (int i = 0; i < KS; i++) begin
                sh_m[i]  = dflt(i);
                act_m[i] = dflt(i);
            end
            exp_q.delete();
        end else begin
            if (cfg_we && int'(cfg_addr) < KS) sh_m[cfg_addr] = int'($signed(cfg_data));
            if (last_acc) begin
                if (s_tuser) act_m = sh_m;
                exp_q.push_back({s_tuser, s_tlast, model(s_tdata, act_m)});
            end
        end
        @(posedge clk);
        #1;
        if (rst) got_q.delete();
    endtask

    task automatic send(input logic [KS*PW-1:0] t, input logic u, input logic l);
        int n;
        s_tvalid = 1'b1; s_tdata = t; s_tuser = u; s_tlast = l;
        n = 0;
        do begin
            do_edge();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) check("send_timeout", 0, 1);
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic cfg_write(input int a, input logic [CW-1:0] d);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = d;
        do_edge();
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (8) do_edge();
    endtask

    task automatic pop_check(input string name, input logic [9:0] exp);
        logic [31:0] a;
        if (got_q.size() == 0) a = 32'hDEAD;
        else a = {22'b0, got_q.pop_front()};
        check(name, a, {22'b0, exp});
    endtask

    initial begin
        int acc_cnt, k, cyc, acc_total, tmp;
        logic stable, seen;
        logic [9:0] held, e;
        logic [31:0] a;

        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
        m_tready = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        do_edge();
        do_edge();
        rst = 1'b0;

        // Reset state
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tuser", m_tuser, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_s_tready", s_tready, 1);

        // Default identity kernel and 3-edge latency
        s_tvalid = 1'b1; s_tdata = mk(8'hFF, 5, 8'h7B); s_tuser = 1'b1;
        do_edge();
        check("lat_accept", last_acc, 1);
        s_tvalid = 1'b0; s_tuser = 1'b0;
        check("lat_e1_vld", m_tvalid, 0);
        do_edge();
        check("lat_e2_vld", m_tvalid, 0);
        do_edge();
        check("lat_e3_vld", m_tvalid, 1);
        check("lat_e3_data", m_tdata, 8'h7B);
        check("lat_e3_user", m_tuser, 1);
        drain();
        got_q.delete(); exp_q.delete();

        // Table of identity-kernel vectors
        tbl[0] = '{mk(8'hFF, 5, 8'h00), 1'b1, 1'b0, 8'h00};
        tbl[1] = '{mk(8'h00, 5, 8'hFF), 1'b0, 1'b0, 8'hFF};
        tbl[2] = '{mk(8'hAA, 5, 8'h80), 1'b0, 1'b0, 8'h80};
        tbl[3] = '{mk(8'hFF, 5, 8'h01), 1'b0, 1'b1, 8'h01};
        tbl[4] = '{mk(8'h12, 5, 8'h5A), 1'b1, 1'b0, 8'h5A};
        tbl[5] = '{mk(8'h00, 5, 8'hC3), 1'b0, 1'b1, 8'hC3};
        for (int i = 0; i < 6; i++) send(tbl[i].taps, tbl[i].user, tbl[i].last);
        drain();
        for (int i = 0; i < 6; i++)
            pop_check($sformatf("tbl_%0d", i), {tbl[i].user, tbl[i].last, tbl[i].exp});

        // Saturation high: all coefficients 127
        for (int i = 0; i < KS; i++) cfg_write(i, 8'h7F);
        send(mk(8'hFF, 0, 8'hFF), 1'b1, 1'b0);
        drain();
        pop_check("sat_hi", {2'b10, 8'hFF});

        // Saturation low: all coefficients -1
        for (int i = 0; i < KS; i++) cfg_write(i, 8'hFF);
        send(mk(8'hFF, 0, 8'hFF), 1'b1, 1'b0);
        drain();
        pop_check("sat_lo", {2'b10, 8'h00});

        // Rounding: coeff[0]=1, others 0
        cfg_write(0, 8'h01);
        for (int i = 1; i < KS; i++) cfg_write(i, 8'h00);
        send(mk(8'hAA, 0, 8'h08), 1'b1, 1'b0);
        send(mk(8'hAA, 0, 8'h07), 1'b0, 1'b0);
        send(mk(8'hAA, 0, 8'h18), 1'b0, 1'b1);
        drain();
        pop_check("rnd_half_up", {2'b10, 8'h01});
        pop_check("rnd_below_half", {2'b00, 8'h00});
        pop_check("rnd_two", {2'b01, 8'h02});

        // Commit boundary: mid-frame shadow writes wait for the next frame start
        cfg_write(0, 8'h00);
        cfg_write(5, 8'h10);
        for (int i = 0; i < 3; i++) send(mk2(8'h33, 0, 8'h20, 5, 8'h55), 1'b0, 1'b0);
        s_tvalid = 1'b1; s_tdata = mk2(8'h33, 0, 8'h20, 5, 8'h55); s_tuser = 1'b1;
        cfg_we = 1'b1; cfg_addr = AW'(5); cfg_data = 8'h20;
        do_edge();
        check("commit_accept", last_acc, 1);
        cfg_we = 1'b0; s_tvalid = 1'b0; s_tuser = 1'b0;
        send(mk2(8'h33, 0, 8'h20, 5, 8'h55), 1'b0, 1'b1);
        drain();
        for (int i = 0; i < 3; i++) pop_check($sformatf("commit_old_%0d", i), {2'b00, 8'h02});
        pop_check("commit_new_sof", {2'b10, 8'hAA});
        pop_check("commit_new_next", {2'b01, 8'hAA});

        // Backpressure: active kernel is now 2*tap[5]
        m_tready = 1'b0; s_tvalid = 1'b1; k = 0; s_tdata = mk(8'h00, 5, 8'h10);
        acc_cnt = 0; stable = 1'b1; seen = 1'b0; held = '0;
        for (int c = 0; c < 10; c++) begin
            do_edge();
            if (last_acc) begin
                acc_cnt++; k++;
                s_tdata = mk(8'h00, 5, 8'(8'h10 + k));
            end
            if (m_tvalid) begin
                if (!seen) begin
                    seen = 1'b1; held = {m_tuser, m_tlast, m_tdata};
                end else if ({m_tuser, m_tlast, m_tdata} != held) begin
                    stable = 1'b0;
                end
            end else if (seen) begin
                stable = 1'b0;
            end
        end
        check("bp_accepts", acc_cnt, 3);
        check("bp_s_tready_low", s_tready, 0);
        check("bp_m_tvalid", m_tvalid, 1);
        check("bp_stable", stable, 1);
        check("bp_hold_data", held, {2'b00, 8'h20});
        s_tvalid = 1'b0; m_tready = 1'b1;
        #1;
        check("bp_ready_rise", s_tready, 1);
        drain();
        check("bp_count", got_q.size(), 3);
        pop_check("bp_out_0", {2'b00, 8'h20});
        pop_check("bp_out_1", {2'b00, 8'h22});
        pop_check("bp_out_2", {2'b00, 8'h24});
        got_q.delete(); exp_q.delete();

        // Random valid/ready and coefficient traffic against the model
        acc_total = 0; cyc = 0; last_acc = 1'b0;
        while (acc_total < 1000 && cyc < 20000) begin
            if (!s_tvalid || last_acc) begin
                s_tvalid = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < KS; i++) s_tdata[i*PW +: PW] = 8'($urandom);
                s_tuser = ($urandom_range(0, 9) == 0);
                s_tlast = ($urandom_range(0, 7) == 0);
            end
            m_tready = ($urandom_range(0, 3) != 0);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_addr = AW'($urandom_range(0, (1 << AW) - 1));
            tmp = int'($urandom_range(0, 24)) - 4;
            cfg_data = tmp[CW-1:0];
            do_edge();
            if (last_acc) acc_total++;
            cyc++;
        end
        check("rand_budget", acc_total, 1000);
        cfg_we = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
        drain();
        check("rand_count", got_q.size(), exp_q.size());
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) a = 32'hDEAD;
            else a = {22'b0, got_q.pop_front()};
            check($sformatf("rand_%0d", k), a, {22'b0, e});
            k++;
        end
        got_q.delete();

        // Reset with three beats in flight and a pending shadow write
        m_tready = 1'b0;
        cfg_write(5, 8'hFB);
        for (int i = 0; i < 3; i++) send(mk(8'h00, 5, 8'h40), 1'b0, 1'b0);
        check("rst_full_vld", m_tvalid, 1);
        rst = 1'b1;
        do_edge();
        rst = 1'b0;
        check("rst_mid_vld", m_tvalid, 0);
        check("rst_mid_data", m_tdata, 0);
        check("rst_mid_ready", s_tready, 1);
        m_tready = 1'b1;
        send(mk(8'hFF, 5, 8'h66), 1'b0, 1'b1);
        send(mk(8'hFF, 5, 8'h3C), 1'b1, 1'b0);
        drain();
        check("rst_out_count", got_q.size(), 2);
        pop_check("rst_active_default", {2'b01, 8'h66});
        pop_check("rst_shadow_default", {2'b10, 8'h3C});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
